// File: rtl/eth_pkg.sv
// Shared types for the Ethernet transmit arbiter: the 74-bit FIFO word layout
// and the arbiter FSM state encoding.
package eth_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned WORD_W = DATA_W + KEEP_W + 2;
  localparam int unsigned CRED_W = 8;

  // Packed MSB-first so the bit positions match the FIFO word: [73] user, [72] last.
  typedef struct packed {
    logic              user;
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } eth_word_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StXfer  = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/eth_txarb_oreg.sv
// One-entry first-word-fall-through output register sitting between the
// arbiter and the consumer; a load and a pop may happen in the same cycle.
module eth_txarb_oreg
  import eth_pkg::*;
(
  input  logic      clk156,
  input  logic      sys_rst,
  input  logic      load,
  input  eth_word_t din,
  input  logic      pop,
  output eth_word_t dout,
  output logic      valid,
  output logic      ready
);

  eth_word_t word_q;
  logic      valid_q;

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load) begin
        word_q  <= din;
        valid_q <= 1'b1;
      end else if (pop && valid_q) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign dout  = word_q;
  assign valid = valid_q;
  assign ready = ~valid_q | pop;

endmodule

// File: rtl/eth_txarb.sv
// Two-source weighted round-robin packet arbiter feeding a FWFT output
// register, with per-packet beat limit and truncate-and-drain of overlong packets.
module eth_txarb
  import eth_pkg::*;
#(
  parameter int unsigned WEIGHT0   = 1,
  parameter int unsigned WEIGHT1   = 1,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic              clk156,
  input  logic              sys_rst,
  input  logic [WORD_W-1:0] fifo0_dout,
  input  logic              fifo0_empty,
  output logic              fifo0_rd_en,
  input  logic [WORD_W-1:0] fifo1_dout,
  input  logic              fifo1_empty,
  output logic              fifo1_rd_en,
  output logic [WORD_W-1:0] dout,
  output logic              empty,
  input  logic              rd_en,
  output logic [31:0]       pkt_cnt0,
  output logic [31:0]       pkt_cnt1,
  output logic [15:0]       trunc_cnt
);

  localparam int unsigned BEAT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BEATS);
  localparam logic [CRED_W-1:0] CRED0 = CRED_W'(WEIGHT0);
  localparam logic [CRED_W-1:0] CRED1 = CRED_W'(WEIGHT1);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              rr_q, rr_d;
  logic [CRED_W-1:0] credit0_q, credit0_d, credit1_q, credit1_d, cred_left;
  logic [BEAT_W-1:0] beat_q, beat_d, beat_inc;
  logic [31:0]       pkt_cnt0_q, pkt_cnt1_q;
  logic [15:0]       trunc_cnt_q;

  eth_word_t src_word, oreg_din, oreg_dout;
  logic      sel, cur, src_empty, oth_empty;
  logic      oreg_valid, oreg_ready, oreg_pop, load, pop_src;
  logic      pkt_done, pkt_cnt_inc, trunc_inc;

  // In IDLE the arbitration choice is used combinationally so the first word of
  // the next packet is taken in the cycle right after the previous last word.
  assign sel       = (!fifo0_empty && !fifo1_empty) ? rr_q : fifo0_empty;
  assign cur       = (state_q == StIdle) ? sel : gnt_q;
  assign src_word  = cur ? eth_word_t'(fifo1_dout) : eth_word_t'(fifo0_dout);
  assign src_empty = cur ? fifo1_empty : fifo0_empty;
  assign oth_empty = cur ? fifo0_empty : fifo1_empty;
  assign oreg_pop  = rd_en & oreg_valid;
  assign beat_inc  = beat_q + BEAT_W'(1);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    beat_d      = beat_q;
    load        = 1'b0;
    pop_src     = 1'b0;
    pkt_done    = 1'b0;
    pkt_cnt_inc = 1'b0;
    trunc_inc   = 1'b0;
    oreg_din    = src_word;
    unique case (state_q)
      StIdle, StXfer: begin
        if (!src_empty && oreg_ready && !sys_rst) begin
          pop_src = 1'b1;
          load    = 1'b1;
          gnt_d   = cur;
          if (src_word.last) begin
            pkt_done    = 1'b1;
            pkt_cnt_inc = 1'b1;
            beat_d      = '0;
            state_d     = StIdle;
          end else if (beat_inc == BEAT_MAX) begin
            oreg_din.last = 1'b1;
            oreg_din.user = 1'b1;
            pkt_cnt_inc   = 1'b1;
            trunc_inc     = 1'b1;
            beat_d        = '0;
            state_d       = StDrain;
          end else begin
            beat_d  = beat_inc;
            state_d = StXfer;
          end
        end
      end
      StDrain: begin
        // Remainder of a truncated packet is discarded, never loaded.
        if (!src_empty && !sys_rst) begin
          pop_src = 1'b1;
          if (src_word.last) begin
            pkt_done = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rr_d      = rr_q;
    credit0_d = credit0_q;
    credit1_d = credit1_q;
    cred_left = (cur ? credit1_q : credit0_q) - CRED_W'(1);
    if (pkt_done) begin
      if (cred_left == '0) begin
        if (cur) credit1_d = CRED1;
        else     credit0_d = CRED0;
        // Hand the turn over only when the other source actually has work.
        if (!oth_empty) begin
          rr_d = ~cur;
          if (cur) credit0_d = CRED0;
          else     credit1_d = CRED1;
        end
      end else begin
        if (cur) credit1_d = cred_left;
        else     credit0_d = cred_left;
      end
    end
  end

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      gnt_q       <= 1'b0;
      rr_q        <= 1'b0;
      credit0_q   <= CRED0;
      credit1_q   <= CRED1;
      beat_q      <= '0;
      pkt_cnt0_q  <= '0;
      pkt_cnt1_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      credit0_q <= credit0_d;
      credit1_q <= credit1_d;
      beat_q    <= beat_d;
      if (pkt_cnt_inc) begin
        if (cur) pkt_cnt1_q <= pkt_cnt1_q + 32'd1;
        else     pkt_cnt0_q <= pkt_cnt0_q + 32'd1;
      end
      if (trunc_inc && (trunc_cnt_q != 16'hFFFF)) begin
        trunc_cnt_q <= trunc_cnt_q + 16'd1;
      end
    end
  end

  eth_txarb_oreg u_oreg (
    .clk156 (clk156),
    .sys_rst(sys_rst),
    .load   (load),
    .din    (oreg_din),
    .pop    (oreg_pop),
    .dout   (oreg_dout),
    .valid  (oreg_valid),
    .ready  (oreg_ready)
  );

  assign fifo0_rd_en = pop_src & ~cur;
  assign fifo1_rd_en = pop_src & cur;
  assign dout        = oreg_dout;
  assign empty       = ~oreg_valid;
  assign pkt_cnt0    = pkt_cnt0_q;
  assign pkt_cnt1    = pkt_cnt1_q;
  assign trunc_cnt   = trunc_cnt_q;

  a_one_pop: assert property (@(posedge clk156) disable iff (sys_rst)
    !(fifo0_rd_en && fifo1_rd_en));
  a_pop_nonempty: assert property (@(posedge clk156) disable iff (sys_rst)
    !(fifo0_rd_en && fifo0_empty) && !(fifo1_rd_en && fifo1_empty));

endmodule

// File: tb/tb_eth_txarb.sv
// Scoreboard bench for eth_txarb: source FIFOs are modelled as queues, expected
// output words are queued by the stimulus and compared by an independent monitor.
module tb_eth_txarb;

  logic        clk156 = 1'b0;
  logic        sys_rst = 1'b1;
  logic [73:0] fifo0_dout = '0;
  logic [73:0] fifo1_dout = '0;
  logic        fifo0_empty = 1'b1;
  logic        fifo1_empty = 1'b1;
  logic        fifo0_rd_en, fifo1_rd_en;
  logic [73:0] dout;
  logic        empty;
  logic        rd_en = 1'b1;
  logic [31:0] pkt_cnt0, pkt_cnt1;
  logic [15:0] trunc_cnt;

  logic [73:0] q0[$];
  logic [73:0] q1[$];
  logic [73:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops0 = 0;
  int pops1 = 0;
  int first_cyc = -1;
  int last_cyc = -1;

  always #5 clk156 = ~clk156;

  eth_txarb #(
    .WEIGHT0  (2),
    .WEIGHT1  (1),
    .MAX_BEATS(8)
  ) dut (
    .clk156     (clk156),
    .sys_rst    (sys_rst),
    .fifo0_dout (fifo0_dout),
    .fifo0_empty(fifo0_empty),
    .fifo0_rd_en(fifo0_rd_en),
    .fifo1_dout (fifo1_dout),
    .fifo1_empty(fifo1_empty),
    .fifo1_rd_en(fifo1_rd_en),
    .dout       (dout),
    .empty      (empty),
    .rd_en      (rd_en),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1),
    .trunc_cnt  (trunc_cnt)
  );

  // Data field = {8'hA0+src, pkt[23:0], beat[31:0]}, keep all ones.
  function automatic logic [73:0] mk(int src, int pkt, int beat, bit last, bit user);
    logic [73:0] w;
    w[63:56] = 8'hA0 + src[7:0];
    w[55:32] = pkt[23:0];
    w[31:0]  = beat;
    w[71:64] = 8'hFF;
    w[72]    = last;
    w[73]    = user;
    return w;
  endfunction

  task automatic add_pkt(int src, int pkt, int len);
    for (int b = 0; b < len; b++) begin
      if (src == 0) q0.push_back(mk(src, pkt, b, b == len - 1, 1'b0));
      else          q1.push_back(mk(src, pkt, b, b == len - 1, 1'b0));
    end
  endtask

  task automatic exp_pkt(int src, int pkt, int len);
    for (int b = 0; b < len; b++) exp_q.push_back(mk(src, pkt, b, b == len - 1, 1'b0));
  endtask

  task automatic check(string name, logic [73:0] got, logic [73:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic check_reset(string tag);
    check({tag, "_empty"}, 74'(empty), 74'(1));
    check({tag, "_dout"}, dout, '0);
    check({tag, "_rd_en0"}, 74'(fifo0_rd_en), '0);
    check({tag, "_rd_en1"}, 74'(fifo1_rd_en), '0);
    check({tag, "_pkt_cnt0"}, 74'(pkt_cnt0), '0);
    check({tag, "_pkt_cnt1"}, 74'(pkt_cnt1), '0);
    check({tag, "_trunc_cnt"}, 74'(trunc_cnt), '0);
  endtask

  task automatic wait_done(string name, int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !empty) && n < budget) begin
      @(negedge clk156);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || !empty) begin
      errors++;
      $display("FAIL %s_timeout: %0d words outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_beat(string name, int beat);
    int n = 0;
    while (!(!empty && dout[31:0] == beat) && n < 100) begin
      @(negedge clk156);
      n++;
    end
    check({name, "_seen"}, 74'(!empty && dout[31:0] == beat), 74'(1));
  endtask

  task automatic do_reset();
    @(negedge clk156);
    sys_rst = 1'b1;
    repeat (2) @(negedge clk156);
    sys_rst = 1'b0;
  endtask

  // Source FIFO model: pop on the edge the DUT saw rd_en, refresh heads after.
  always @(posedge clk156) begin
    logic p0, p1;
    p0 = fifo0_rd_en;
    p1 = fifo1_rd_en;
    cyc++;
    checks++;
    if ((p0 && fifo0_empty) || (p1 && fifo1_empty) || (p0 && p1)) begin
      errors++;
      $display("FAIL rd_en_rule: rd_en0=%0b rd_en1=%0b empty0=%0b empty1=%0b, required legal pop",
               p0, p1, fifo0_empty, fifo1_empty);
    end
    #1;
    if (p0 && q0.size() > 0) begin q0.delete(0); pops0++; end
    if (p1 && q1.size() > 0) begin q1.delete(0); pops1++; end
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
    fifo0_dout  = fifo0_empty ? '0 : q0[0];
    fifo1_dout  = fifo1_empty ? '0 : q1[0];
  end

  always @(negedge clk156) begin
    if (!sys_rst && !empty && rd_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h, required no output", dout);
      end else begin
        if (dout !== exp_q[0]) begin
          errors++;
          $display("FAIL dout_word: got %h, required %h", dout, exp_q[0]);
        end
        exp_q.delete(0);
      end
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (3) @(negedge clk156);
    check_reset("por");
    sys_rst = 1'b0;

    // Single source, three 4-word packets back-to-back.
    s = pops1;
    first_cyc = -1;
    for (int p = 0; p < 3; p++) begin
      add_pkt(0, p, 4);
      exp_pkt(0, p, 4);
    end
    wait_done("single_src", 100);
    check("b2b_span", 74'(last_cyc - first_cyc), 74'(11));
    check("single_pkt_cnt0", 74'(pkt_cnt0), 74'(3));
    check("single_pkt_cnt1", 74'(pkt_cnt1), 74'(0));
    check("single_no_pop1", 74'(pops1 - s), 74'(0));

    // Reset while the second word of a packet is on dout.
    add_pkt(0, 10, 4);
    exp_pkt(0, 10, 4);
    wait_beat("mid_rst", 1);
    #1;
    sys_rst = 1'b1;
    #1;
    check_reset("mid");
    check("mid_fifo_left", 74'(q0.size()), 74'(2));
    exp_q.delete();
    exp_q.push_back(mk(0, 10, 2, 1'b0, 1'b0));
    exp_q.push_back(mk(0, 10, 3, 1'b1, 1'b0));
    @(negedge clk156);
    #1;
    sys_rst = 1'b0;
    wait_done("post_rst", 50);
    check("post_rst_pkt_cnt0", 74'(pkt_cnt0), 74'(1));

    // Weighted 2:1 arbitration with both sources backlogged.
    do_reset();
    for (int i = 0; i < 6; i++) add_pkt(0, 20 + i, 4);
    for (int i = 0; i < 3; i++) add_pkt(1, 30 + i, 4);
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 2) exp_pkt(1, 30 + k / 3, 4);
      else            exp_pkt(0, 20 + (k / 3) * 2 + k % 3, 4);
    end
    wait_done("weighted", 300);
    check("weighted_pkt_cnt0", 74'(pkt_cnt0), 74'(6));
    check("weighted_pkt_cnt1", 74'(pkt_cnt1), 74'(3));

    // 12-word packet truncated at 8 beats, then an intact 2-word packet.
    add_pkt(0, 40, 12);
    add_pkt(0, 41, 2);
    for (int b = 0; b < 7; b++) exp_q.push_back(mk(0, 40, b, 1'b0, 1'b0));
    exp_q.push_back(mk(0, 40, 7, 1'b1, 1'b1));
    exp_pkt(0, 41, 2);
    wait_done("trunc", 100);
    check("trunc_cnt", 74'(trunc_cnt), 74'(1));
    check("trunc_pkt_cnt0", 74'(pkt_cnt0), 74'(8));
    check("trunc_drained", 74'(q0.size()), 74'(0));

    // Consumer stall of 5 cycles inside an exactly-8-word packet.
    add_pkt(1, 50, 8);
    exp_pkt(1, 50, 8);
    wait_beat("stall", 2);
    @(posedge clk156);
    #1;
    rd_en = 1'b0;
    #1;
    s = pops1;
    repeat (5) begin
      @(negedge clk156);
      check("stall_dout", dout, mk(1, 50, 3, 1'b0, 1'b0));
      check("stall_empty", 74'(empty), 74'(0));
    end
    check("stall_pops_le1", 74'((pops1 - s) <= 1), 74'(1));
    @(posedge clk156);
    #1;
    rd_en = 1'b1;
    wait_done("stall", 100);
    check("stall_pkt_cnt1", 74'(pkt_cnt1), 74'(4));
    check("full_len_no_trunc", 74'(trunc_cnt), 74'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
